ifid_fetch: RTL and testbench
=============================

IFID_FETCH -- requirements
Module: ifid_fetch

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-003 SHALL have port stall, input, 1, decode-side hold; IF/ID contents frozen while high.
REQ-004 SHALL have port redirect, input, 1, branch/jal/jalr taken; flush and reload PC.
REQ-005 SHALL have port redirect_pc, input, 8, target byte address for redirect.
REQ-006 SHALL have port imem_req, output, 1, instruction fetch request.
REQ-007 SHALL have port imem_addr, output, 8, fetch byte address, equal to internal PC.
REQ-008 SHALL have port imem_gnt, input, 1, request accepted this cycle.
REQ-009 SHALL have port imem_valid, input, 1, read data valid (at least 1 cycle after grant).
REQ-010 SHALL have port imem_rdata, input, 32, fetched instruction.
REQ-011 SHALL have port pc_out, output, 8, PC of instruction_out (not incremented).
REQ-012 SHALL have port instruction_out, output, 32, instruction to decode / ID-EX register.
REQ-013 SHALL have port valid_out, output, 1, instruction_out is a real instruction, not a bubble.

Function
REQ-014 SHALL keep an 8-bit PC; each instruction delivered to IF/ID advances PC by 4, modulo 256 (8'hFC -> 8'h00).
REQ-015 SHALL allow at most one outstanding memory request.
REQ-016 SHALL implement states REQ, WAIT, HOLD, DRAIN.
REQ-017 REQ: imem_req=1, imem_addr=PC held stable; on imem_gnt -> WAIT.
REQ-018 WAIT: imem_req=0; on imem_valid with stall=0, load IF/ID {PC, imem_rdata, valid=1}, PC+=4, -> REQ.
REQ-019 WAIT: on imem_valid with stall=1, capture imem_rdata into a 32-bit hold buffer, -> HOLD.
REQ-020 HOLD: imem_req=0; when stall=0, load IF/ID from hold buffer with valid=1, PC+=4, -> REQ.
REQ-021 DRAIN: imem_req=0; discard the returning response; on imem_valid -> REQ.
REQ-022 Redirect SHALL take priority over stall and any load: PC<=redirect_pc, IF/ID <= {redirect_pc, NOP, valid=0}, hold buffer discarded.
REQ-023 Redirect next state: REQ when in REQ with gnt=0 or in HOLD; DRAIN when in REQ with gnt=1, WAIT with imem_valid=0, or DRAIN with imem_valid=0; REQ when in WAIT/DRAIN with imem_valid=1 (that response discarded).
REQ-024 While stall=1 and redirect=0, IF/ID SHALL hold pc_out, instruction_out, valid_out unchanged.
REQ-025 With stall=0, redirect=0 and no load this cycle, IF/ID SHALL take a bubble: instruction_out=NOP, valid_out=0, pc_out unchanged.
REQ-026 NOP SHALL be 32'h0000_0013.
REQ-027 Minimum throughput SHALL be one instruction per 2 cycles with single-cycle memory latency.

Reset
REQ-028 On rst: state=REQ, PC=RESET_PC (8'h00), hold buffer=0, pc_out=8'h00, instruction_out=NOP, valid_out=0, imem_req=0 while rst high.
REQ-029 rst asserted mid-request SHALL abandon it; first post-reset request issued the first cycle after rst deasserts with imem_addr=8'h00.

Structure
REQ-030 RESET_PC, NOP encoding, PC_STEP (4), and the state enum SHALL live in the shared core package.
REQ-031 The IF/ID output register SHALL be a sub-module ifid_reg (load, hold, flush controls); FSM and PC stay in ifid_fetch.

Verification
REQ-032 Reset then gnt=1 immediately and valid 1 cycle later, rdata=32'h00500093 -> pc_out=00, instruction_out=00500093, valid_out=1; next imem_addr=04.
REQ-033 Stall held 3 cycles during imem_valid at PC=08 -> IF/ID unchanged, no new imem_req; on stall release, pc_out=08 with buffered data, then imem_addr=0C.
REQ-034 Redirect to 8'h40 in WAIT with imem_valid=0 -> bubble (valid_out=0, NOP); next response discarded; next imem_addr=40.
REQ-035 Redirect and stall together in HOLD -> flush wins, buffer dropped, imem_req=1 with imem_addr=40 next cycle.
REQ-036 PC at 8'hFC delivered -> next imem_addr=8'h00.
REQ-037 rst pulsed while in DRAIN -> outputs at reset values, late imem_valid ignored, imem_addr=00 after release.

Source files
------------

// File: rtl/ifid_fetch_pkg.sv
// Shared core constants and the fetch FSM state encoding.
// Used by the fetch stage and its IF/ID output register.
package ifid_fetch_pkg;

   localparam logic [7:0]  RESET_PC = 8'h00;
   localparam logic [7:0]  PC_STEP  = 8'h04;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2,
      S_DRAIN = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/ifid_fetch_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold,
// and with none of them active a bubble (NOP, valid=0) is inserted.
module ifid_reg
   import ifid_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        load,
   input  logic        hold,
   input  logic [7:0]  flush_pc,
   input  logic [7:0]  load_pc,
   input  logic [31:0] load_instr,
   output logic [7:0]  pc_out,
   output logic [31:0] instruction_out,
   output logic        valid_out
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_out          <= RESET_PC;
         instruction_out <= NOP;
         valid_out       <= 1'b0;
      end else if (flush) begin
         pc_out          <= flush_pc;
         instruction_out <= NOP;
         valid_out       <= 1'b0;
      end else if (load) begin
         pc_out          <= load_pc;
         instruction_out <= load_instr;
         valid_out       <= 1'b1;
      end else if (!hold) begin
         // bubble keeps pc_out so decode still sees where the gap sits
         instruction_out <= NOP;
         valid_out       <= 1'b0;
      end
   end

endmodule

// File: rtl/ifid_fetch.sv
// Instruction fetch stage: one-outstanding-request memory FSM, PC and
// stall hold buffer, feeding the IF/ID register.
module ifid_fetch
   import ifid_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [7:0]  redirect_pc,
   output logic        imem_req,
   output logic [7:0]  imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   output logic [7:0]  pc_out,
   output logic [31:0] instruction_out,
   output logic        valid_out
);

   fetch_state_t state, state_nxt;
   logic [7:0]   pc;
   logic [31:0]  hold_buf;
   logic         load;
   logic [31:0]  load_instr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_REQ;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_REQ: begin
            // an accepted request must have its response drained on redirect
            if (imem_gnt) state_nxt = redirect ? S_DRAIN : S_WAIT;
         end
         S_WAIT: begin
            if (imem_valid) begin
               if (redirect)   state_nxt = S_REQ;
               else if (stall) state_nxt = S_HOLD;
               else            state_nxt = S_REQ;
            end else if (redirect) begin
               state_nxt = S_DRAIN;
            end
         end
         S_HOLD: begin
            if (redirect || !stall) state_nxt = S_REQ;
         end
         S_DRAIN: begin
            if (imem_valid) state_nxt = S_REQ;
         end
         default: state_nxt = S_REQ;
      endcase
   end

   assign load       = !redirect && !stall &&
                       ((state == S_WAIT && imem_valid) || state == S_HOLD);
   assign load_instr = (state == S_HOLD) ? hold_buf : imem_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           pc <= RESET_PC;
      else if (redirect) pc <= redirect_pc;
      else if (load)     pc <= pc + PC_STEP;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         hold_buf <= '0;
      else if (redirect)
         hold_buf <= '0;
      else if (state == S_WAIT && imem_valid && stall)
         hold_buf <= imem_rdata;
   end

   assign imem_req  = (state == S_REQ) && !rst;
   assign imem_addr = pc;

   ifid_reg u_ifid_reg (
      .clk             (clk),
      .rst             (rst),
      .flush           (redirect),
      .load            (load),
      .hold            (stall),
      .flush_pc        (redirect_pc),
      .load_pc         (pc),
      .load_instr      (load_instr),
      .pc_out          (pc_out),
      .instruction_out (instruction_out),
      .valid_out       (valid_out)
   );

endmodule

// File: tb/tb_ifid_fetch.sv
// Directed bench for ifid_fetch: reset, fetch, stall hold, redirect
// flush, PC wrap and reset during drain.
module tb_ifid_fetch;

   localparam logic [31:0] NOP_I = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [7:0]  redirect_pc;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_gnt;
   logic        imem_valid;
   logic [31:0] imem_rdata;
   logic [7:0]  pc_out;
   logic [31:0] instruction_out;
   logic        valid_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ifid_fetch dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_gnt        (imem_gnt),
      .imem_valid      (imem_valid),
      .imem_rdata      (imem_rdata),
      .pc_out          (pc_out),
      .instruction_out (instruction_out),
      .valid_out       (valid_out)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // full fetch: grant in REQ, response one cycle later, no stall
   task automatic do_fetch(input logic [7:0] pc, input logic [7:0] prev_pc,
                           input logic [31:0] data, input string name);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== pc) begin
         errors++;
         $display("FAIL %s req: req=%b addr=%h expected req=1 addr=%h", name, imem_req, imem_addr, pc);
      end
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      checks++;
      if (imem_req !== 1'b0 || valid_out !== 1'b0 || instruction_out !== NOP_I || pc_out !== prev_pc) begin
         errors++;
         $display("FAIL %s wait/bubble: req=%b valid=%b instr=%h pc=%h expected 0 0 %h %h",
                  name, imem_req, valid_out, instruction_out, pc_out, NOP_I, prev_pc);
      end
      imem_valid = 1'b1;
      imem_rdata = data;
      step();
      imem_valid = 1'b0;
      checks++;
      if (pc_out !== pc || instruction_out !== data || valid_out !== 1'b1) begin
         errors++;
         $display("FAIL %s load: pc=%h instr=%h valid=%b expected %h %h 1",
                  name, pc_out, instruction_out, valid_out, pc, data);
      end
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== pc + 8'h04) begin
         errors++;
         $display("FAIL %s next: req=%b addr=%h expected req=1 addr=%h", name, imem_req, imem_addr, pc + 8'h04);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
      imem_gnt = 1'b0; imem_valid = 1'b0; imem_rdata = 32'h0;
      step(); step();
      checks++;
      if (pc_out !== 8'h00 || instruction_out !== NOP_I || valid_out !== 1'b0 || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: pc=%h instr=%h valid=%b req=%b expected 00 %h 0 0",
                  pc_out, instruction_out, valid_out, imem_req, NOP_I);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
         errors++;
         $display("FAIL reset_first_req: req=%b addr=%h expected 1 00", imem_req, imem_addr);
      end
   endtask

   task automatic test_first_fetch();
      do_fetch(8'h00, 8'h00, 32'h0050_0093, "first_fetch");
      do_fetch(8'h04, 8'h00, 32'h0010_0113, "second_fetch");
   endtask

   task automatic test_stall_hold();
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      imem_valid = 1'b1; imem_rdata = 32'h0020_8193; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         imem_valid = 1'b0;
         checks++;
         if (imem_req !== 1'b0 || pc_out !== 8'h04 || instruction_out !== NOP_I || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: req=%b pc=%h instr=%h valid=%b expected 0 04 %h 0",
                     i, imem_req, pc_out, instruction_out, valid_out, NOP_I);
         end
      end
      stall = 1'b0;
      step();
      checks++;
      if (pc_out !== 8'h08 || instruction_out !== 32'h0020_8193 || valid_out !== 1'b1) begin
         errors++;
         $display("FAIL stall_release: pc=%h instr=%h valid=%b expected 08 00208193 1",
                  pc_out, instruction_out, valid_out);
      end
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h0C) begin
         errors++;
         $display("FAIL stall_next_addr: req=%b addr=%h expected 1 0c", imem_req, imem_addr);
      end
      do_fetch(8'h0C, 8'h08, 32'h0031_0233, "after_stall");
   endtask

   task automatic test_redirect_wait();
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      redirect = 1'b1; redirect_pc = 8'h40;
      step();
      redirect = 1'b0;
      checks++;
      if (valid_out !== 1'b0 || instruction_out !== NOP_I || pc_out !== 8'h40 || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL redirect_flush: valid=%b instr=%h pc=%h req=%b expected 0 %h 40 0",
                  valid_out, instruction_out, pc_out, imem_req, NOP_I);
      end
      imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      step();
      imem_valid = 1'b0;
      checks++;
      if (valid_out !== 1'b0 || instruction_out !== NOP_I || imem_req !== 1'b1 || imem_addr !== 8'h40) begin
         errors++;
         $display("FAIL redirect_discard: valid=%b instr=%h req=%b addr=%h expected 0 %h 1 40",
                  valid_out, instruction_out, imem_req, imem_addr, NOP_I);
      end
      do_fetch(8'h40, 8'h40, 32'h0041_8293, "redirect_target");
   endtask

   task automatic test_redirect_hold();
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      imem_valid = 1'b1; imem_rdata = 32'hBAD0_BAD0; stall = 1'b1;
      step();
      imem_valid = 1'b0;
      redirect = 1'b1; redirect_pc = 8'h40;
      step();
      redirect = 1'b0; stall = 1'b0;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h40 || valid_out !== 1'b0 || instruction_out !== NOP_I || pc_out !== 8'h40) begin
         errors++;
         $display("FAIL hold_redirect: req=%b addr=%h valid=%b instr=%h pc=%h expected 1 40 0 %h 40",
                  imem_req, imem_addr, valid_out, instruction_out, pc_out, NOP_I);
      end
      do_fetch(8'h40, 8'h40, 32'h0052_0313, "hold_refetch");
   endtask

   task automatic test_pc_wrap();
      redirect = 1'b1; redirect_pc = 8'hFC;
      step();
      redirect = 1'b0;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'hFC) begin
         errors++;
         $display("FAIL wrap_redirect: req=%b addr=%h expected 1 fc", imem_req, imem_addr);
      end
      do_fetch(8'hFC, 8'hFC, 32'h0062_8393, "wrap");
   endtask

   task automatic test_reset_in_drain();
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      redirect = 1'b1; redirect_pc = 8'h80;
      step();
      redirect = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if (pc_out !== 8'h00 || instruction_out !== NOP_I || valid_out !== 1'b0 || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL drain_reset: pc=%h instr=%h valid=%b req=%b expected 00 %h 0 0",
                  pc_out, instruction_out, valid_out, imem_req, NOP_I);
      end
      imem_valid = 1'b1; imem_rdata = 32'hCAFE_F00D;
      step();
      rst = 1'b0;
      step();
      imem_valid = 1'b0;
      checks++;
      if (valid_out !== 1'b0 || instruction_out !== NOP_I || imem_req !== 1'b1 || imem_addr !== 8'h00) begin
         errors++;
         $display("FAIL drain_reset_release: valid=%b instr=%h req=%b addr=%h expected 0 %h 1 00",
                  valid_out, instruction_out, imem_req, imem_addr, NOP_I);
      end
      do_fetch(8'h00, 8'h00, 32'h0073_0413, "post_reset");
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_stall_hold();
      test_redirect_wait();
      test_redirect_hold();
      test_pc_wrap();
      test_reset_in_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
